hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_ctrl_load_use_cmp.sv | 22 ++
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller:
// FSM state encoding, the hard-wired zero register and control-bundle width.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hz_state_e;

    localparam logic [4:0] ZERO_REG = 5'd0;

    // branch, memread, memtoreg, memwrite, regwrite, alusrc, aluop[1:0]
    localparam int CTRL_W = 8;

endpackage

// File: rtl/hazard_ctrl_load_use_cmp.sv
// Load-use detector: a load in ID/EX writing a register read by
// the valid instruction in IF/ID.
module load_use_cmp
    import hazard_ctrl_pkg::*;
(
    input  logic       i_ifid_valid,
    input  logic [4:0] i_ifid_rs1,
    input  logic [4:0] i_ifid_rs2,
    input  logic       i_idex_memread,
    input  logic [4:0] i_idex_rd,
    output logic       o_lu
);

    logic w_rs_hit;

    assign w_rs_hit = (i_idex_rd == i_ifid_rs1) |
                      (i_idex_rd == i_ifid_rs2);

    assign o_lu = i_idex_memread & i_ifid_valid &
                  (i_idex_rd != ZERO_REG) & w_rs_hit;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard control FSM: one-cycle load-use stalls and taken-branch flushes.
// Define HAZARD_PERF_EN to build the stall/flush event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifid_valid,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rd,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [1:0] FC_INIT = 2'(FLUSH_CYCLES - 1);

    hz_state_e  r_state;
    hz_state_e  w_state_nx;
    logic [1:0] r_fcnt;
    logic [1:0] w_fcnt_nx;
    logic       w_lu;
    logic       w_stall_ev;
    logic       w_flush_ev;

    load_use_cmp u_lu (
        .i_ifid_valid   (ifid_valid),
        .i_ifid_rs1     (ifid_rs1),
        .i_ifid_rs2     (ifid_rs2),
        .i_idex_memread (idex_memread),
        .i_idex_rd      (idex_rd),
        .o_lu           (w_lu)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_fcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nx;
            r_fcnt  <= w_fcnt_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_fcnt_nx   = r_fcnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        w_stall_ev  = 1'b0;
        w_flush_ev  = 1'b0;
        if (!reset) begin
            w_state_nx = RUN;
            w_fcnt_nx  = 2'd0;
        end else if (r_state == RUN) begin
            // branch wins over a coincident load-use
            priority case (1'b1)
                branch_taken: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    w_flush_ev = 1'b1;
                    w_state_nx = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    w_fcnt_nx  = FC_INIT;
                end
                w_lu: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    w_stall_ev  = 1'b1;
                end
                default: ;
            endcase
        end else begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            w_fcnt_nx  = (r_fcnt != 2'd0) ? r_fcnt - 2'd1 : 2'd0;
            w_state_nx = (r_fcnt <= 2'd1) ? RUN : FLUSH;
        end
    end

    assign state = r_state;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stall_ev && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_flush_ev && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    logic w_unused_ev;

    assign w_unused_ev = w_stall_ev | w_flush_ev;
    assign stall_cnt   = 32'd0;
    assign flush_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (FLUSH_CYCLES=2);
// counter expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifid_valid = 1'b0;
    logic [4:0]  ifid_rs1 = 5'd0;
    logic [4:0]  ifid_rs2 = 5'd0;
    logic        idex_memread = 1'b0;
    logic [4:0]  idex_rd = 5'd0;
    logic        branch_taken = 1'b0;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_bubble;
    logic        ifid_flush;
    logic        idex_flush;
    logic        state;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .ifid_valid   (ifid_valid),
        .ifid_rs1     (ifid_rs1),
        .ifid_rs2     (ifid_rs2),
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .state        (state),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pw, iw, bub, ifl, xfl, st;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] e_s = 32'd0;
    logic [31:0] e_f = 32'd0;

    task automatic cmp(string tag, string fld,
                       logic [31:0] got, logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s.%s got %h want %h", tag, fld, got, want);
        end
    endtask

    task automatic push(string tag, logic pw, logic iw, logic bub,
                        logic ifl, logic xfl, logic st);
        exp_t e;
        e.tag = tag; e.pw = pw; e.iw = iw; e.bub = bub;
        e.ifl = ifl; e.xfl = xfl; e.st = st;
        e.sc = PERF ? e_s : 32'd0;
        e.fc = PERF ? e_f : 32'd0;
        q.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        e = q.pop_front();
        cmp(e.tag, "pc_write",    32'(pc_write),    32'(e.pw));
        cmp(e.tag, "ifid_write",  32'(ifid_write),  32'(e.iw));
        cmp(e.tag, "idex_bubble", 32'(idex_bubble), 32'(e.bub));
        cmp(e.tag, "ifid_flush",  32'(ifid_flush),  32'(e.ifl));
        cmp(e.tag, "idex_flush",  32'(idex_flush),  32'(e.xfl));
        cmp(e.tag, "state",       32'(state),       32'(e.st));
        cmp(e.tag, "stall_cnt",   stall_cnt,        e.sc);
        cmp(e.tag, "flush_cnt",   flush_cnt,        e.fc);
    endtask

    task automatic drive(logic v, logic [4:0] r1, logic [4:0] r2,
                         logic mr, logic [4:0] rd, logic br);
        ifid_valid = v; ifid_rs1 = r1; ifid_rs2 = r2;
        idex_memread = mr; idex_rd = rd; branch_taken = br;
    endtask

    // one clock: drive after the edge, check at the falling edge
    task automatic cyc(string tag, logic v, logic [4:0] r1,
                       logic [4:0] r2, logic mr, logic [4:0] rd,
                       logic br, logic pw, logic iw, logic bub,
                       logic ifl, logic xfl, logic st);
        @(posedge clk);
        #1;
        drive(v, r1, r2, mr, rd, br);
        push(tag, pw, iw, bub, ifl, xfl, st);
        @(negedge clk);
        chk();
        if (rst_n && bub && e_s != '1)
            e_s = e_s + 32'd1;
        if (rst_n && ifl && !st && e_f != '1)
            e_f = e_f + 32'd1;
    endtask

    initial begin
        cyc("rst_br", 1, 5'd5, 5'd5, 1, 5'd5, 1, 1, 1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 5'd0, 5'd0, 0, 5'd0, 0);
        rst_n = 1'b1;

        cyc("idle",     0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, 0, 0, 0);
        cyc("lu_rs2",   1, 5'd3, 5'd5, 1, 5'd5, 0, 0, 0, 1, 0, 0, 0);
        cyc("after_lu", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, 0, 0, 0);
        cyc("rd_zero",  1, 5'd0, 5'd0, 1, 5'd0, 0, 1, 1, 0, 0, 0, 0);
        cyc("lu_rs1",   1, 5'd7, 5'd2, 1, 5'd7, 0, 0, 0, 1, 0, 0, 0);
        cyc("no_valid", 0, 5'd7, 5'd7, 1, 5'd7, 0, 1, 1, 0, 0, 0, 0);
        cyc("no_load",  1, 5'd7, 5'd7, 0, 5'd7, 0, 1, 1, 0, 0, 0, 0);
        cyc("no_match", 1, 5'd1, 5'd2, 1, 5'd9, 0, 1, 1, 0, 0, 0, 0);

        cyc("br",       0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1, 0, 1, 1, 0);
        cyc("fl_br_lu", 1, 5'd4, 5'd4, 1, 5'd4, 1, 1, 1, 0, 1, 1, 1);
        cyc("fl_done",  0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, 0, 0, 0);

        cyc("br_lu",    1, 5'd6, 5'd1, 1, 5'd6, 1, 1, 1, 0, 1, 1, 0);
        cyc("fl2",      0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, 1, 1, 1);
        cyc("run2",     0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, 0, 0, 0);

        cyc("br3",      0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1, 0, 1, 1, 0);
        cyc("fl3",      0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1, 0, 1, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        e_s = 32'd0;
        e_f = 32'd0;
        push("rst_mid", 1, 1, 0, 0, 0, 0);
        chk();
        cyc("rst_hold", 1, 5'd5, 5'd5, 1, 5'd5, 1, 1, 1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 5'd0, 5'd0, 0, 5'd0, 0);
        rst_n = 1'b1;
        cyc("post_rst", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, 0, 0, 0);

`ifdef HAZARD_PERF_EN
        @(posedge clk);
        #1;
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        e_s = 32'hFFFF_FFFE;
`endif
        cyc("sat1",     1, 5'd8, 5'd0, 1, 5'd8, 0, 0, 0, 1, 0, 0, 0);
        cyc("sat2",     1, 5'd0, 5'd8, 1, 5'd8, 0, 0, 0, 1, 0, 0, 0);
        cyc("sat3",     1, 5'd8, 5'd8, 1, 5'd8, 0, 0, 0, 1, 0, 0, 0);
        cyc("sat_hold", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
